// File: rtl/iob_fifo_sync_pkg.sv
// Shared constants and helpers for the iob_fifo_sync FIFO controller.
// The optional almost-full/almost-empty flags are enabled by defining
// the macro IOB_FIFO_SYNC_ALMOST_EN.
package iob_fifo_sync_pkg;

    // Default geometry, matching the RAM the controller is normally paired with.
    localparam int unsigned IOB_FIFO_DEF_DATA_W = 8;
    localparam int unsigned IOB_FIFO_DEF_ADDR_W = 4;

    // FIFO depth in words for a given RAM address width.
    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 2 ** addr_w;
    endfunction

    // Width of the occupancy counter; one extra bit so "full" is representable.
    function automatic int unsigned fifo_level_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/iob_fifo_ptr.sv
// ADDR_W-bit wrapping pointer with enable and synchronous active-low reset.
// Used twice by iob_fifo_sync: once as the write pointer, once as the read pointer.
module iob_fifo_ptr #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Advance by one when enabled; wraps naturally at 2**ADDR_W.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/iob_fifo_sync.sv
// Single-clock FIFO controller driving an external true-dual-port RAM
// (port A = write, port B = read, 1-cycle read latency). Owns the pointers,
// occupancy level and registered full/empty flags; storage lives in the RAM.
// Optional registered almost_full/almost_empty flags: define IOB_FIFO_SYNC_ALMOST_EN.
module iob_fifo_sync
    import iob_fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_W = IOB_FIFO_DEF_DATA_W,
    parameter int unsigned ADDR_W = IOB_FIFO_DEF_ADDR_W
`ifdef IOB_FIFO_SYNC_ALMOST_EN
    ,
    parameter int unsigned ALMOST_FULL_LVL  = 2 ** ADDR_W - 1,
    parameter int unsigned ALMOST_EMPTY_LVL = 1
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              r_empty,
    output logic [ADDR_W:0]   level,
`ifdef IOB_FIFO_SYNC_ALMOST_EN
    output logic              almost_full,
    output logic              almost_empty,
`endif
    output logic              ext_mem_w_en,
    output logic [ADDR_W-1:0] ext_mem_w_addr,
    output logic [DATA_W-1:0] ext_mem_w_data,
    output logic              ext_mem_r_en,
    output logic [ADDR_W-1:0] ext_mem_r_addr,
    input  logic [DATA_W-1:0] ext_mem_r_data
);

    localparam int unsigned DEPTH   = fifo_depth(ADDR_W);
    localparam int unsigned LEVEL_W = fifo_level_w(ADDR_W);

    // Handshake: a push is accepted in any cycle where w_en=1 and the registered
    // w_full=0; a pop is accepted where r_en=1 and the registered r_empty=0.
    // Requests that are not accepted are dropped with no side effects (no
    // retry is implied). An accepted pop returns its word on r_data with
    // r_valid=1 exactly one cycle later; there is no back-pressure on r_data.
    logic push;
    logic pop;

    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W-1:0]  rptr;

    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic               w_full_q;
    logic               w_full_d;
    logic               r_empty_q;
    logic               r_empty_d;
    logic               r_valid_q;
    logic               r_valid_d;

    assign push = w_en & ~w_full_q;
    assign pop  = r_en & ~r_empty_q;

    iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (push),
        .ptr   (wptr)
    );

    iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pop),
        .ptr   (rptr)
    );

    // Next occupancy and flags; flags come from the next level so they
    // change in the same cycle the level does.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
        w_full_d  = (level_d == LEVEL_W'(DEPTH));
        r_empty_d = (level_d == '0);
        r_valid_d = pop;
    end

    // Occupancy, flag and read-valid registers; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q   <= '0;
            w_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
            r_valid_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            w_full_q  <= w_full_d;
            r_empty_q <= r_empty_d;
            r_valid_q <= r_valid_d;
        end
    end

`ifdef IOB_FIFO_SYNC_ALMOST_EN
    logic almost_full_q;
    logic almost_full_d;
    logic almost_empty_q;
    logic almost_empty_d;

    // Threshold flags, also derived from the next level.
    always_comb begin
        almost_full_d  = (level_d >= LEVEL_W'(ALMOST_FULL_LVL));
        almost_empty_d = (level_d <= LEVEL_W'(ALMOST_EMPTY_LVL));
    end

    // Threshold flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

    // RAM port A (write) and port B (read) drive straight from the accept logic.
    // With both push and pop accepted the FIFO is neither empty nor full, so
    // wptr != rptr and the two ports never touch the same address.
    assign ext_mem_w_en   = push;
    assign ext_mem_w_addr = wptr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = pop;
    assign ext_mem_r_addr = rptr;

    assign r_data  = ext_mem_r_data;
    assign r_valid = r_valid_q;
    assign r_empty = r_empty_q;
    assign w_full  = w_full_q;
    assign level   = level_q;

endmodule

// File: tb/tb_iob_fifo_sync.sv
// Directed testbench for iob_fifo_sync with a behavioural true-dual-port RAM.
module tb_iob_fifo_sync;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_empty;
    logic [ADDR_W:0]   level;
    logic              ext_mem_w_en;
    logic [ADDR_W-1:0] ext_mem_w_addr;
    logic [DATA_W-1:0] ext_mem_w_data;
    logic              ext_mem_r_en;
    logic [ADDR_W-1:0] ext_mem_r_addr;
    logic [DATA_W-1:0] ext_mem_r_data;

    int checks;
    int errors;

    logic [DATA_W-1:0] exp_q[$];

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    iob_fifo_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .w_en           (w_en),
        .w_data         (w_data),
        .w_full         (w_full),
        .r_en           (r_en),
        .r_data         (r_data),
        .r_valid        (r_valid),
        .r_empty        (r_empty),
        .level          (level),
        .ext_mem_w_en   (ext_mem_w_en),
        .ext_mem_w_addr (ext_mem_w_addr),
        .ext_mem_w_data (ext_mem_w_data),
        .ext_mem_r_en   (ext_mem_r_en),
        .ext_mem_r_addr (ext_mem_r_addr),
        .ext_mem_r_data (ext_mem_r_data)
    );

    // Behavioural TDP RAM: port A write, port B read with 1-cycle latency.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always @(posedge clk) begin
        if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
        if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
    end

    // Driver tasks
    task automatic apply_reset();
        rst_n  = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        w_en   = 1'b1;
        w_data = d;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    // Scenario 1: idle after reset
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL reset_r_empty got %b exp 1", r_empty); end
        checks++; if (w_full !== 1'b0) begin errors++; $display("FAIL reset_w_full got %b exp 0", w_full); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %b exp 0", r_valid); end
        checks++; if (ext_mem_w_en !== 1'b0) begin errors++; $display("FAIL reset_mem_w_en got %b exp 0", ext_mem_w_en); end
        checks++; if (ext_mem_r_en !== 1'b0) begin errors++; $display("FAIL reset_mem_r_en got %b exp 0", ext_mem_r_en); end
    endtask

    // Scenario 2: fill to full, rejected push, drain in order
    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            w_en   = 1'b1;
            w_data = DATA_W'(32 + i);
            #1;
            checks++; if (ext_mem_w_en !== 1'b1 || ext_mem_w_addr !== ADDR_W'(i)) begin
                errors++; $display("FAIL fill_w_port got en=%b addr=%0d exp en=1 addr=%0d", ext_mem_w_en, ext_mem_w_addr, i);
            end
            @(negedge clk);
        end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d exp 16", level); end
        checks++; if (w_full !== 1'b1) begin errors++; $display("FAIL fill_w_full got %b exp 1", w_full); end
        w_data = 8'hFF;
        #1;
        checks++; if (ext_mem_w_en !== 1'b0) begin errors++; $display("FAIL full_push_rejected got %b exp 0", ext_mem_w_en); end
        @(negedge clk);
        w_en = 1'b0;
        #1;
        checks++; if (ext_mem_w_addr !== 4'd0 || level !== 5'd16) begin
            errors++; $display("FAIL full_wptr_level got addr=%0d level=%0d exp addr=0 level=16", ext_mem_w_addr, level);
        end
        for (int i = 0; i < 16; i++) begin
            r_en = 1'b1;
            #1;
            checks++; if (ext_mem_r_en !== 1'b1 || ext_mem_r_addr !== ADDR_W'(i)) begin
                errors++; $display("FAIL drain_r_port got en=%b addr=%0d exp en=1 addr=%0d", ext_mem_r_en, ext_mem_r_addr, i);
            end
            @(negedge clk);
            checks++; if (r_valid !== 1'b1 || r_data !== DATA_W'(32 + i)) begin
                errors++; $display("FAIL drain_data got v=%b d=%0d exp v=1 d=%0d", r_valid, r_data, 32 + i);
            end
        end
        r_en = 1'b0;
        checks++; if (r_empty !== 1'b1 || level !== 5'd0) begin
            errors++; $display("FAIL drain_empty got empty=%b level=%0d exp 1/0", r_empty, level);
        end
        @(negedge clk);
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_drop got %b exp 0", r_valid); end
    endtask

    // Scenario 3: pop while empty is ignored
    task automatic test_pop_empty();
        r_en = 1'b1;
        #1;
        checks++; if (ext_mem_r_en !== 1'b0) begin errors++; $display("FAIL empty_pop_mem_r_en got %b exp 0", ext_mem_r_en); end
        @(negedge clk);
        r_en = 1'b0;
        checks++; if (r_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL empty_pop got v=%b level=%0d exp 0/0", r_valid, level);
        end
    endtask

    // Scenario 4: steady streaming with pointer wrap
    task automatic test_back_to_back();
        int pops;
        pops = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_word(DATA_W'(64 + i));
            exp_q.push_back(DATA_W'(64 + i));
        end
        checks++; if (level !== 5'd8) begin errors++; $display("FAIL prefill_level got %0d exp 8", level); end
        for (int i = 0; i < 16; i++) begin
            w_en   = 1'b1;
            w_data = DATA_W'(72 + i);
            r_en   = 1'b1;
            exp_q.push_back(DATA_W'(72 + i));
            @(negedge clk);
            pops++;
            checks++; if (r_valid !== 1'b1 || r_data !== exp_q[0]) begin
                errors++; $display("FAIL stream_data got v=%b d=%0d exp v=1 d=%0d", r_valid, r_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            checks++; if (level !== 5'd8) begin errors++; $display("FAIL stream_level got %0d exp 8", level); end
        end
        w_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            @(negedge clk);
            pops++;
            checks++; if (r_valid !== 1'b1 || r_data !== exp_q[0]) begin
                errors++; $display("FAIL stream_drain got v=%b d=%0d exp v=1 d=%0d", r_valid, r_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        r_en = 1'b0;
        checks++; if (pops !== 24 || r_empty !== 1'b1 || exp_q.size() !== 0) begin
            errors++; $display("FAIL stream_end got pops=%0d empty=%b left=%0d exp 24/1/0", pops, r_empty, exp_q.size());
        end
        @(negedge clk);
    endtask

    // Scenario 5: simultaneous push and pop at full and at empty
    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) push_word(DATA_W'(100 + i));
        w_en   = 1'b1;
        w_data = 8'h77;
        r_en   = 1'b1;
        #1;
        checks++; if (ext_mem_w_en !== 1'b0 || ext_mem_r_en !== 1'b1) begin
            errors++; $display("FAIL full_both_ports got w=%b r=%b exp w=0 r=1", ext_mem_w_en, ext_mem_r_en);
        end
        @(negedge clk);
        w_en = 1'b0;
        checks++; if (level !== 5'd15 || w_full !== 1'b0) begin
            errors++; $display("FAIL full_both_level got level=%0d full=%b exp 15/0", level, w_full);
        end
        checks++; if (r_valid !== 1'b1 || r_data !== 8'd100) begin
            errors++; $display("FAIL full_both_data got v=%b d=%0d exp 1/100", r_valid, r_data);
        end
        repeat (15) @(negedge clk);
        r_en = 1'b0;
        checks++; if (r_empty !== 1'b1 || level !== 5'd0) begin
            errors++; $display("FAIL full_drain got empty=%b level=%0d exp 1/0", r_empty, level);
        end
        @(negedge clk);
        w_en   = 1'b1;
        w_data = 8'h3C;
        r_en   = 1'b1;
        #1;
        checks++; if (ext_mem_w_en !== 1'b1 || ext_mem_r_en !== 1'b0) begin
            errors++; $display("FAIL empty_both_ports got w=%b r=%b exp w=1 r=0", ext_mem_w_en, ext_mem_r_en);
        end
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        checks++; if (level !== 5'd1 || r_valid !== 1'b0 || r_empty !== 1'b0) begin
            errors++; $display("FAIL empty_both got level=%0d v=%b empty=%b exp 1/0/0", level, r_valid, r_empty);
        end
    endtask

    // Scenario 6: reset during operation drops data and in-flight read
    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_word(DATA_W'(200 + i));
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL pre_reset_level got %0d exp 5", level); end
        r_en  = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        r_en  = 1'b0;
        rst_n = 1'b1;
        checks++; if (r_valid !== 1'b0 || level !== 5'd0 || r_empty !== 1'b1 || w_full !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%b level=%0d empty=%b full=%b exp 0/0/1/0", r_valid, level, r_empty, w_full);
        end
        push_word(8'hA5);
        r_en = 1'b1;
        @(negedge clk);
        r_en = 1'b0;
        checks++; if (r_valid !== 1'b1 || r_data !== 8'hA5) begin
            errors++; $display("FAIL post_reset_data got v=%b d=%h exp 1/a5", r_valid, r_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_drain();
        test_pop_empty();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_fifo_sync.md
Name: iob_fifo_sync

Overview:
Single-clock synchronous FIFO controller that drives an external true-dual-port RAM.
- RAM port A is the write port; RAM port B is the read port. Both RAM clocks are tied to clk.
- Owns the pointers, occupancy count and full/empty flags. Storage lives entirely in the RAM.
- Sits directly upstream of the dual-port RAM and provides a push/pop interface to producer and consumer logic.

Parameters:
- DATA_W, 8, data word width; must match the RAM DATA_W.
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  synchronous, active-low reset.
- w_en  in  1  push request.
- w_data  in  DATA_W  push data.
- w_full  out  1  FIFO full.
- r_en  in  1  pop request.
- r_data  out  DATA_W  pop data; valid while r_valid=1.
- r_valid  out  1  r_data valid; asserted the cycle after an accepted pop.
- r_empty  out  1  FIFO empty.
- level  out  ADDR_W+1  number of stored words, 0 to 2**ADDR_W.
- ext_mem_w_en  out  1  RAM port A enable and write enable.
- ext_mem_w_addr  out  ADDR_W  RAM port A address.
- ext_mem_w_data  out  DATA_W  RAM port A data in.
- ext_mem_r_en  out  1  RAM port B enable; port B write enable tied 0 externally.
- ext_mem_r_addr  out  ADDR_W  RAM port B address.
- ext_mem_r_data  in  DATA_W  RAM port B data out (1-cycle read latency).

Behaviour:
- Reset (rst_n=0 sampled at a clk rising edge):
  - wptr=0, rptr=0, level=0, r_valid=0, r_empty=1, w_full=0.
  - RAM contents are not cleared.
  - Reset asserted mid-operation discards all queued data and any in-flight read: r_valid=0 on the next cycle.
- Push accept: push = w_en & ~w_full, where w_full is the registered flag.
  - Combinationally: ext_mem_w_en=push, ext_mem_w_addr=wptr, ext_mem_w_data=w_data.
  - On the clock edge: wptr <= wptr+1, mod 2**ADDR_W, natural wrap.
- Pop accept: pop = r_en & ~r_empty.
  - Combinationally: ext_mem_r_en=pop, ext_mem_r_addr=rptr.
  - On the clock edge: rptr <= rptr+1 with wrap; r_valid <= pop.
  - r_data = ext_mem_r_data passthrough. Data is valid exactly one cycle after the pop.
- Rejected requests: w_en while full, or r_en while empty, is silently ignored. Pointers, level and RAM are unchanged.
- Level update:
  - +1 on push only; -1 on pop only.
  - Unchanged when push and pop occur together, or when neither occurs.
  - Width is ADDR_W+1, so level never wraps.
- Flags: registered and derived from the next level.
  - w_full = (level_next == 2**ADDR_W).
  - r_empty = (level_next == 0).
  - Both are valid in the same cycle that level updates.
- Simultaneous push and pop:
  - Non-empty and non-full: both are accepted, level is unchanged, and read/write addresses differ.
  - Empty: only the push is accepted; the pop is rejected.
  - Full: only the pop is accepted; the push is rejected.
  - The write to the old rptr slot is therefore never read in the same cycle. No RAM read-during-write collision occurs on one address.
- Throughput: one push and one pop per cycle sustained. First-word read latency is push at cycle N, pop allowed at N+1, data at N+2.

Optional Feature:
IOB_FIFO_SYNC_ALMOST_EN
- When defined:
  - Adds parameters ALMOST_FULL_LVL (default 2**ADDR_W-1) and ALMOST_EMPTY_LVL (default 1).
  - Adds outputs almost_full and almost_empty.
  - almost_full = (level_next >= ALMOST_FULL_LVL) and almost_empty = (level_next <= ALMOST_EMPTY_LVL), both registered.
  - Reset values: almost_full=0, almost_empty=1.
- When undefined: these parameters and ports do not exist, and there is no extra logic.

Decomposition:
- Shared package/header: FIFO depth constant (2**ADDR_W) and level width (ADDR_W+1) as localparams, plus the macro name.
- One natural sub-module, iob_fifo_ptr: ADDR_W-bit wrapping counter with enable and synchronous active-low reset. It is instantiated twice, once for wptr and once for rptr.
- The RAM is instantiated outside this block, one level up.

Test Plan (DATA_W=8, ADDR_W=4, bench instantiates iob_fifo_sync plus the TDP RAM):
1. Reset, then idle → r_empty=1, w_full=0, level=0, r_valid=0, ext_mem_w_en=0, ext_mem_r_en=0.
2. Push 32..47 on 16 consecutive cycles → level=16, w_full=1 after the 16th push. A 17th push of 0xFF is ignored and wptr is unchanged. Then pop 16 times → r_data=32..47 in order, each one cycle after its pop; r_empty=1 after the last pop.
3. Pop while empty → no ext_mem_r_en, r_valid=0, level stays 0.
4. Pre-fill 8 words (64..71), then push 72..87 while popping every cycle → level stays 8, pointers wrap past 15, and the pop sequence is 64..87 with no gaps or duplicates.
5. Full FIFO, assert w_en and r_en together → pop accepted, push rejected, level=15. Empty FIFO, assert both together → push accepted, pop rejected, level=1, r_valid=0.
6. Level=5 with a pop in flight, assert rst_n=0 for one cycle → r_valid=0 the next cycle, level=0, r_empty=1. A following push/pop of 0xA5 returns 0xA5.
